// File: rtl/lif_pkg.sv
// Shared definitions for the LIF layer timestep sequencer and its index counter.
package lif_pkg;

    // Index width shared with the layer counter; N_IN/N_OUT must fit below 2**IDX_W.
    localparam int IDX_W     = 6;
    localparam int N_IN_DEF  = 30;
    localparam int N_OUT_DEF = 30;
    localparam int MAX_LAT   = 7;

    // Sequencer states, 3-bit encoding.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        ACC   = 3'd2,
        DRAIN = 3'd3,
        UPD   = 3'd4,
        NEXT  = 3'd5,
        DONE  = 3'd6
    } lif_state_e;

    // State-decoded strobes, registered together with the state.
    typedef struct packed {
        logic clr_all;
        logic acc_init;
        logic next_out;
        logic mem_rd_en;
        logic acc_clr;
        logic vmem_upd;
        logic busy;
        logic done;
    } lif_strb_t;

    // Strobe pattern shown while sitting in state s.
    function automatic lif_strb_t lif_decode(lif_state_e s);
        lif_strb_t o;
        o      = '0;
        o.busy = (s != IDLE);
        case (s)
            CLR: begin
                o.clr_all = 1'b1;
                o.acc_clr = 1'b1;
            end
            ACC:  o.mem_rd_en = 1'b1;
            UPD:  o.vmem_upd  = 1'b1;
            NEXT: begin
                o.next_out = 1'b1;
                o.acc_init = 1'b1;
                o.acc_clr  = 1'b1;
            end
            DONE: o.done = 1'b1;
            default: ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/lif_dly.sv
// 1-bit delay line with async reset and synchronous flush; DEPTH=0 is a wire.
module lif_dly #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic d,
    output logic q
);

    generate
        if (DEPTH == 0) begin : g_wire
            // Clock, reset and flush have no effect without storage.
            logic unused_in;
            assign unused_in = clk ^ rst ^ flush;
            assign q = d;
        end else begin : g_sr
            logic [DEPTH-1:0] sr;

            // Shift d in at bit 0; a flush empties every stage in flight.
            always_ff @(posedge clk or posedge rst) begin
                if (rst)        sr <= '0;
                else if (flush) sr <= '0;
                else            sr <= (sr << 1) | DEPTH'(d);
            end

            assign q = sr[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/lif_seq_ctrl.sv
// Timestep sequencer for one LIF layer: walks the index counter over
// N_OUT x N_IN, issues memory reads, aligned accumulate strobes and one
// membrane update per output neuron, then pulses done.
module lif_seq_ctrl
    import lif_pkg::*;
#(
    parameter int N_OUT   = N_OUT_DEF,
    parameter int N_IN    = N_IN_DEF,
    parameter int MEM_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic abort,
    input  logic ini_last,
    input  logic out_last,
    output logic clr_all,
    output logic acc_init,
    output logic acc_step,
    output logic next_out,
    output logic mem_rd_en,
    output logic acc_clr,
    output logic acc_en,
    output logic vmem_upd,
    output logic busy,
    output logic done
);

    // Loop lengths come from the counter flags; the sizes only need range checks.
    generate
        if (N_OUT < 1 || N_OUT >= (1 << IDX_W) ||
            N_IN  < 1 || N_IN  >= (1 << IDX_W) ||
            MEM_LAT < 0 || MEM_LAT > MAX_LAT) begin : g_param_err
            $error("lif_seq_ctrl: N_OUT/N_IN must be 1..63 and MEM_LAT 0..7");
        end
    endgenerate

    lif_state_e state, nxt;
    lif_strb_t  strb;
    logic [2:0] drain_cnt;
    logic       dly_q;

    // Next-state selection; abort overrides everything but rst.
    always_comb begin
        nxt = state;
        if (abort) begin
            nxt = IDLE;
        end else begin
            case (state)
                IDLE:  if (start) nxt = CLR;
                CLR:   nxt = ACC;
                ACC:   if (ini_last) nxt = (MEM_LAT > 0) ? DRAIN : UPD;
                DRAIN: if (drain_cnt == 3'(MEM_LAT - 1)) nxt = UPD;
                UPD:   nxt = out_last ? DONE : NEXT;
                NEXT:  nxt = ACC;
                DONE:  nxt = IDLE;
                default: nxt = IDLE;
            endcase
        end
    end

    // State, drain counter and strobes register together so outputs are Moore.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            strb      <= '0;
            drain_cnt <= '0;
        end else begin
            state     <= nxt;
            strb      <= lif_decode(nxt);
            drain_cnt <= (state == DRAIN && nxt == DRAIN) ? drain_cnt + 3'd1 : 3'd0;
        end
    end

    // An aborting cycle issues no strobe; busy still reflects the held state.
    assign clr_all   = strb.clr_all   & ~abort;
    assign acc_init  = strb.acc_init  & ~abort;
    assign next_out  = strb.next_out  & ~abort;
    assign mem_rd_en = strb.mem_rd_en & ~abort;
    assign acc_clr   = strb.acc_clr   & ~abort;
    assign vmem_upd  = strb.vmem_upd  & ~abort;
    assign done      = strb.done      & ~abort;
    assign busy      = strb.busy;

    // The input index parks on N_IN-1 after the last read of a neuron.
    assign acc_step  = strb.mem_rd_en & ~ini_last & ~abort;

    // acc_en follows mem_rd_en by the memory latency; abort drops reads in flight.
    lif_dly #(.DEPTH(MEM_LAT)) u_dly (
        .clk   (clk),
        .rst   (rst),
        .flush (abort),
        .d     (mem_rd_en),
        .q     (dly_q)
    );

    assign acc_en = dly_q & ~abort;

endmodule
